// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates COUNT unsigned sum words per block and then
// holds the total (with an overflow flag) until downstream accepts it.
// Optional build macro: SUM_ACC_SAT_EN. When it is defined, the accumulator
// saturates on overflow. When it is undefined, the accumulator wraps.
module sum_accumulator #(
  parameter int unsigned SUM_W = 5,
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             in_xfer;
  logic             out_xfer;
  logic             last;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign last     = (cnt == CNT_W'(COUNT - 1));
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};

  // Next accumulator value; the extra sum bit flags overflow
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
`ifdef SUM_ACC_SAT_EN
    if (sum[ACC_W]) acc_nxt = '1;
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator, sample counter and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (in_xfer) begin
      acc <= acc_nxt;
      ovf <= ovf | sum[ACC_W];
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end else if (out_xfer) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  assign out_acc = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator: default configuration,
// a narrow accumulator (ACC_W=6) for overflow, and a single-sample block (COUNT=1).
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default instance
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [4:0] in_sum;
  logic [6:0] out_acc;

  // ACC_W = 6 instance
  logic       v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_out_ovf;
  logic [4:0] v_in_sum;
  logic [5:0] v_out_acc;

  // COUNT = 1 instance
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [4:0] c_in_sum;
  logic [6:0] c_out_acc;

  sum_accumulator #(.SUM_W(5), .COUNT(4), .ACC_W(7)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  sum_accumulator #(.SUM_W(5), .COUNT(4), .ACC_W(6)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_sum(v_in_sum), .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_acc(v_out_acc), .out_ovf(v_out_ovf)
  );

  sum_accumulator #(.SUM_W(5), .COUNT(1), .ACC_W(7)) u_one (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sum(c_in_sum), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_acc(c_out_acc), .out_ovf(c_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one sample on the default instance
  task automatic send(input logic [4:0] s);
    in_valid = 1'b1;
    in_sum   = s;
    check("accum_in_ready", {31'd0, in_ready}, 32'd1);
    check("accum_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  logic [5:0] ovf_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
    v_in_valid = 1'b0; v_in_sum = '0; v_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_sum = '0; c_out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_acc", {25'd0, out_acc}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

    // Back-to-back samples 6,11,7,4
    send(5'd6); send(5'd11); send(5'd7); send(5'd4);
    check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd0);
    check("b2b_out_acc", {25'd0, out_acc}, 32'd28);
    check("b2b_out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    check("b2b_consumed_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_consumed_ready", {31'd0, in_ready}, 32'd1);
    check("b2b_cleared_acc", {25'd0, out_acc}, 32'd0);

    // Same samples with two idle cycles before each
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gap_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("gap_in_ready", {31'd0, in_ready}, 32'd1);
      case (i)
        0: send(5'd6);
        1: send(5'd11);
        2: send(5'd7);
        default: send(5'd4);
      endcase
    end
    check("gap_out_valid", {31'd0, out_valid}, 32'd1);
    check("gap_out_acc", {25'd0, out_acc}, 32'd28);
    tick();
    check("gap_consumed", {31'd0, out_valid}, 32'd0);

    // Backpressure: hold for 5 cycles while upstream offers 31
    out_ready = 1'b0;
    send(5'd6); send(5'd11); send(5'd7); send(5'd4);
    in_valid = 1'b1; in_sum = 5'd31;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_acc", {25'd0, out_acc}, 32'd28);
      check("bp_out_ovf", {31'd0, out_ovf}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_consumed_valid", {31'd0, out_valid}, 32'd0);
    check("bp_consumed_acc", {25'd0, out_acc}, 32'd0);

    // Reset mid-block discards the partial sum
    send(5'd6); send(5'd11);
    check("mid_partial_acc", {25'd0, out_acc}, 32'd17);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_acc", {25'd0, out_acc}, 32'd0);
    send(5'd1); send(5'd2); send(5'd3);
    check("mid_no_early_result", {31'd0, out_valid}, 32'd0);
    send(5'd4);
    check("mid_out_valid", {31'd0, out_valid}, 32'd1);
    check("mid_out_acc", {25'd0, out_acc}, 32'd10);
    tick();

    // Reset while holding a result drops it
    out_ready = 1'b0;
    send(5'd1); send(5'd1); send(5'd1); send(5'd1);
    check("hold_pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("hold_rst_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rst_acc", {25'd0, out_acc}, 32'd0);
    check("hold_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Overflow on ACC_W=6: four samples of 31
    v_in_valid = 1'b1; v_in_sum = 5'd31;
    tick(); tick();
    check("ovf_no_flag_yet", {31'd0, v_out_ovf}, 32'd0);
    check("ovf_acc_62", {26'd0, v_out_acc}, 32'd62);
    tick(); tick();
    v_in_valid = 1'b0;
`ifdef SUM_ACC_SAT_EN
    ovf_exp = 6'd63;
`else
    ovf_exp = 6'd60;
`endif
    check("ovf_out_valid", {31'd0, v_out_valid}, 32'd1);
    check("ovf_out_ovf", {31'd0, v_out_ovf}, 32'd1);
    check("ovf_out_acc", {26'd0, v_out_acc}, {26'd0, ovf_exp});
    tick();
    check("ovf_cleared_flag", {31'd0, v_out_ovf}, 32'd0);
    check("ovf_cleared_acc", {26'd0, v_out_acc}, 32'd0);

    // COUNT=1: every sample is its own block
    c_in_valid = 1'b1; c_in_sum = 5'd9;
    tick();
    c_in_valid = 1'b0;
    check("one_first_valid", {31'd0, c_out_valid}, 32'd1);
    check("one_first_ready", {31'd0, c_in_ready}, 32'd0);
    check("one_first_acc", {25'd0, c_out_acc}, 32'd9);
    tick();
    check("one_between_ready", {31'd0, c_in_ready}, 32'd1);
    check("one_between_acc", {25'd0, c_out_acc}, 32'd0);
    c_in_valid = 1'b1; c_in_sum = 5'd17;
    tick();
    c_in_valid = 1'b0;
    check("one_second_valid", {31'd0, c_out_valid}, 32'd1);
    check("one_second_acc", {25'd0, c_out_acc}, 32'd17);
    tick();
    check("one_second_consumed", {31'd0, c_out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
